// File: rtl/radix4.sv
// Iterative signed multiplier: radix-4 Booth recoding, one digit per clock,
// N/2 iterations per product. start is level-sensitive and restarts from any state.
module radix4 #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   inputA,
    input  logic [N-1:0]   inputB,
    output logic [2*N-1:0] out,
    output logic           done
);
    localparam int ITER = N / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           bm1_q, bm1_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] out_q, out_d;
    logic           done_q, done_d;

    logic [2:0]     trip;
    logic [N+1:0]   a_ext, pp;
    logic [2*N-1:0] pp_ext, pp_sh, sum;

    // Two guard bits keep -2A exact for the most negative multiplicand.
    assign a_ext  = {{2{a_q[N-1]}}, a_q};
    // b_q shifts right two bits per digit, so the current triplet is always at the bottom.
    assign trip   = {b_q[1], b_q[0], bm1_q};

    always_comb begin
        pp = '0;
        case (trip)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
    end

    assign pp_ext = {{(N-2){pp[N+1]}}, pp};
    assign pp_sh  = pp_ext << {cnt_q, 1'b0};
    assign sum    = acc_q + pp_sh;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bm1_d   = bm1_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = done_q;
        if (start) begin
            state_d = LOAD;
            a_d     = inputA;
            b_d     = inputB;
            bm1_d   = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                LOAD, RUN: begin
                    acc_d   = sum;
                    b_d     = {2'b00, b_q[N-1:2]};
                    bm1_d   = b_q[1];
                    cnt_d   = cnt_q + CW'(1);
                    state_d = RUN;
                    if (cnt_q == LAST) begin
                        out_d   = sum;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bm1_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bm1_q   <= bm1_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
endmodule

// File: tb/tb_radix4.sv
// Bench for radix4: vector table plus scoreboard of expected products,
// with hand sequences for abort, async reset and back-to-back operation.
module tb_radix4;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [31:0] inputA, inputB;
    logic        [63:0] out;
    logic               done;

    int nchecks = 0;
    int nerrors = 0;
    logic signed [63:0] sb[$];

    typedef struct {
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [63:0] p;
    } vec_t;
    vec_t tbl[$];

    radix4 #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .inputA(inputA), .inputB(inputB),
        .out(out), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1. Drives start for ncyc edges, then waits for done.
    task automatic do_mul(input logic signed [31:0] a, input logic signed [31:0] b,
                          input int ncyc, input logic signed [63:0] exp, input string nm);
        int cyc;
        bit got;
        logic signed [63:0] e;
        inputA = a;
        inputB = b;
        start  = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1 start = 1'b0;
        sb.push_back(exp);
        inputA = $urandom;
        inputB = $urandom;
        cyc = 0;
        got = 1'b0;
        while (cyc < 40 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            got = done;
        end
        e = sb.pop_front();
        if (!got) begin
            nchecks++;
            nerrors++;
            $display("FAIL %s_timeout: done not seen within 40 cycles, expected %0d", nm, e);
        end else begin
            check({nm, "_latency"}, cyc, 16);
            check(nm, out, e);
        end
    endtask

    initial begin
        logic signed [63:0] prev;
        longint la, lb;

        tbl.push_back('{32'sd1348760118, 32'sd1348543286, 64'sd1818861401553467748});
        tbl.push_back('{32'sd1348543286, 32'sd1348760118, 64'sd1818861401553467748});
        tbl.push_back('{32'sd553524, -32'sd259, -64'sd143362716});
        tbl.push_back('{-32'sd259, 32'sd553524, -64'sd143362716});
        tbl.push_back('{32'sd1348760118, -32'sd1199060305, -64'sd1617244718460915990});
        tbl.push_back('{-32'sd1199060305, 32'sd1348760118, -64'sd1617244718460915990});
        tbl.push_back('{-32'sd2, -32'sd2, 64'sd4});
        tbl.push_back('{-32'sd259, -32'sd259, 64'sd67081});
        tbl.push_back('{-32'sd1199060305, -32'sd2005095693, 64'sd2404230653202766365});
        tbl.push_back('{32'sh80000000, 32'sh80000000, 64'sd4611686018427387904});
        tbl.push_back('{32'sh80000000, 32'sd2147483647, -64'sd4611686016279904256});
        tbl.push_back('{32'sd2147483647, 32'sh80000000, -64'sd4611686016279904256});
        tbl.push_back('{32'sd1, 32'sd1348760118, 64'sd1348760118});
        tbl.push_back('{-32'sd1199060305, 32'sd1, -64'sd1199060305});
        tbl.push_back('{32'sd0, 32'sd1348760118, 64'sd0});
        tbl.push_back('{-32'sd1199060305, 32'sd0, 64'sd0});
        tbl.push_back('{32'sd5, 32'sd0, 64'sd0});

        rst_n  = 1'b0;
        start  = 1'b0;
        inputA = '0;
        inputB = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out", out, 64'sd0);
        check("reset_done", {63'd0, done}, 64'sd1 - 64'sd1);
        @(posedge clk);
        #1;

        do_mul(32'sd553524, 32'sd840, 3, 64'sd464960160, "basic");
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("hold_out", out, 64'sd464960160);
            check("hold_done", {63'd0, done}, 64'sd1);
        end

        for (int i = 0; i < tbl.size(); i++)
            do_mul(tbl[i].a, tbl[i].b, (i % 3) + 1, tbl[i].p, $sformatf("tbl%0d", i));

        // Abort: (7,9) restarted at cycle 8 by (3,-4); 63 must never reach out.
        prev   = out;
        inputA = 32'sd7;
        inputB = 32'sd9;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check("abort_done_low", {63'd0, done}, 64'sd0);
            check("abort_out_held", out, prev);
        end
        do_mul(32'sd3, -32'sd4, 1, -64'sd12, "abort_restart");
        repeat (20) begin
            @(posedge clk);
            #1;
            check("abort_final", out, -64'sd12);
        end

        // Asynchronous reset in the middle of a run.
        inputA = 32'sd123;
        inputB = 32'sd456;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", out, 64'sd0);
        check("async_rst_done", {63'd0, done}, 64'sd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_done", {63'd0, done}, 64'sd0);
        do_mul(-32'sd1000, 32'sd77, 2, -64'sd77000, "post_rst");

        // Back-to-back random operations, one start pulse every 52 cycles.
        for (int i = 0; i < 14; i++) begin
            logic signed [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            la = ra;
            lb = rb;
            do_mul(ra, rb, 2, la * lb, $sformatf("rand%0d", i));
            repeat (34) @(posedge clk);
            #1;
        end

        if (sb.size() != 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", nchecks);
        $fatal(1, "timeout");
    end
endmodule
